vga_layer_renderer: RTL



---
 rtl/vga_layer_renderer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vga_layer_renderer.sv
// Breakout pixel renderer: composites slider, ball, obstacle pads, a flashing destroyed
// brick and the brick grid. Geometry and brick state are snapshotted per frame; the pipeline has 2-cycle latency.
module vga_layer_renderer #(
  parameter int unsigned COLOR_W      = 10,
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned TILE_SHIFT   = 5,
  parameter int unsigned GRID_COLS    = 20,
  parameter int unsigned GRID_ROWS    = 15,
  parameter int unsigned SLIDER_HW    = 50,
  parameter int unsigned SLIDER_HH    = 20,
  parameter int unsigned BALL_R       = 10,
  parameter int unsigned OBSA_X0      = 100,
  parameter int unsigned OBSA_Y0      = 280,
  parameter int unsigned OBSB_X0      = 500,
  parameter int unsigned OBSB_Y0      = 230,
  parameter int unsigned OBS_W        = 96,
  parameter int unsigned OBS_H        = 32,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic                           iVGA_CLK,
  input  logic                           iRST_n,
  input  logic [COORD_W-1:0]             iVGA_X,
  input  logic [COORD_W-1:0]             iVGA_Y,
  input  logic                           iHS,
  input  logic                           iVS,
  input  logic                           iBLANK_n,
  input  logic [COORD_W-1:0]             iSlider_x,
  input  logic [COORD_W-1:0]             iSlider_y,
  input  logic [COORD_W-1:0]             iBall_x,
  input  logic [COORD_W-1:0]             iBall_y,
  input  logic [GRID_COLS*GRID_ROWS-1:0] iState_flag,
  input  logic [1:0]                     iSlider_flag,
  output logic [COLOR_W-1:0]             oRed,
  output logic [COLOR_W-1:0]             oGreen,
  output logic [COLOR_W-1:0]             oBlue,
  output logic                           oHS,
  output logic                           oVS,
  output logic                           oBLANK_n
);

  localparam int unsigned SW     = COORD_W + 2;
  localparam int unsigned NBRICK = GRID_COLS * GRID_ROWS;
  localparam int unsigned IDX_W  = $clog2(NBRICK);
  localparam int unsigned TC_W   = COORD_W - TILE_SHIFT;
  localparam int unsigned CNT_W  = $clog2(FLASH_FRAMES + 1);

  localparam logic signed [SW-1:0] SLD_HW = SW'(SLIDER_HW);
  localparam logic signed [SW-1:0] SLD_HH = SW'(SLIDER_HH);
  localparam logic signed [SW-1:0] BALL_L = SW'(BALL_R);
  localparam logic [SW-1:0] A_X0 = SW'(OBSA_X0);
  localparam logic [SW-1:0] A_X1 = SW'(OBSA_X0 + OBS_W);
  localparam logic [SW-1:0] A_Y0 = SW'(OBSA_Y0);
  localparam logic [SW-1:0] A_Y1 = SW'(OBSA_Y0 + OBS_H);
  localparam logic [SW-1:0] B_X0 = SW'(OBSB_X0);
  localparam logic [SW-1:0] B_X1 = SW'(OBSB_X0 + OBS_W);
  localparam logic [SW-1:0] B_Y0 = SW'(OBSB_Y0);
  localparam logic [SW-1:0] B_Y1 = SW'(OBSB_Y0 + OBS_H);

  // Widened signed distance so a centre near 0 never wraps to the far screen edge.
  function automatic logic nearAxis(input logic [COORD_W-1:0] p, input logic [COORD_W-1:0] c,
                                    input logic signed [SW-1:0] lim);
    logic signed [SW-1:0] d;
    d = $signed(SW'(p)) - $signed(SW'(c));
    return (d <= lim) && (d >= -lim);
  endfunction

  function automatic logic inSpan(input logic [COORD_W-1:0] p, input logic [SW-1:0] lo,
                                  input logic [SW-1:0] hi);
    return (SW'(p) >= lo) && (SW'(p) <= hi);
  endfunction

  logic                 vsPrev;
  logic [COORD_W-1:0]   sliderX, sliderY, ballX, ballY;
  logic [1:0]           obsEn;
  logic [NBRICK-1:0]    stateSnap;
  logic [IDX_W-1:0]     flashIdx;
  logic [CNT_W-1:0]     flashCnt;

  logic                 hs1, vs1, blank1, interior1, outGrid1, sliderHit1, ballHit1, inA1, inB1;
  logic [IDX_W-1:0]     idx1;

  logic                 frameStart;
  logic [NBRICK-1:0]    cleared;
  logic [IDX_W-1:0]     clearIdx;
  logic [TC_W-1:0]      tileCol, tileRow;
  logic [COLOR_W-1:0]   pixR, pixG, pixB;

  // Lowest newly destroyed brick wins the flash.
  always_comb begin
    frameStart = !iVS && vsPrev;
    cleared    = stateSnap & ~iState_flag;
    clearIdx   = '0;
    for (int i = NBRICK - 1; i >= 0; i--) begin
      if (cleared[i]) clearIdx = IDX_W'(i);
    end
    tileCol = iVGA_X[COORD_W-1:TILE_SHIFT];
    tileRow = iVGA_Y[COORD_W-1:TILE_SHIFT];
  end

  always_comb begin
    pixR = '0;
    pixG = '0;
    pixB = '0;
    if (blank1) begin
      if (sliderHit1) begin
        pixG = COLOR_W'(8);
        pixB = COLOR_W'(8);
      end else if (ballHit1) begin
        pixR = COLOR_W'(12);
        pixG = COLOR_W'(12);
        pixB = COLOR_W'(12);
      end else if (inA1 || inB1) begin
        // Obstacle footprint masks the grid even while the pad is disabled.
        if ((inA1 && obsEn[0]) || (!inA1 && obsEn[1])) begin
          pixR = COLOR_W'(9);
          pixG = COLOR_W'(8);
          pixB = COLOR_W'(1);
        end
      end else if (!outGrid1 && interior1) begin
        if (idx1 == flashIdx && flashCnt != '0) begin
          pixR = '1;
          pixG = '1;
          pixB = '1;
        end else if (stateSnap[idx1]) begin
          pixR = COLOR_W'(15);
          pixB = COLOR_W'(7);
        end
      end
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      vsPrev     <= 1'b1;
      sliderX    <= '0;
      sliderY    <= '0;
      ballX      <= '0;
      ballY      <= '0;
      obsEn      <= '0;
      stateSnap  <= '0;
      flashIdx   <= '0;
      flashCnt   <= '0;
      hs1        <= 1'b1;
      vs1        <= 1'b1;
      blank1     <= 1'b0;
      interior1  <= 1'b0;
      outGrid1   <= 1'b0;
      sliderHit1 <= 1'b0;
      ballHit1   <= 1'b0;
      inA1       <= 1'b0;
      inB1       <= 1'b0;
      idx1       <= '0;
      oRed       <= '0;
      oGreen     <= '0;
      oBlue      <= '0;
      oHS        <= 1'b1;
      oVS        <= 1'b1;
      oBLANK_n   <= 1'b0;
    end else begin
      vsPrev <= iVS;
      if (frameStart) begin
        sliderX   <= iSlider_x;
        sliderY   <= iSlider_y;
        ballX     <= iBall_x;
        ballY     <= iBall_y;
        obsEn     <= iSlider_flag;
        stateSnap <= iState_flag;
        if (cleared != '0) begin
          flashIdx <= clearIdx;
          flashCnt <= CNT_W'(FLASH_FRAMES);
        end else if (flashCnt != '0) begin
          flashCnt <= flashCnt - CNT_W'(1);
        end
      end

      hs1        <= iHS;
      vs1        <= iVS;
      blank1     <= iBLANK_n;
      idx1       <= IDX_W'(32'(tileCol) + 32'(tileRow) * 32'(GRID_COLS));
      interior1  <= (iVGA_X[TILE_SHIFT-1:0] != '0) && (iVGA_Y[TILE_SHIFT-1:0] != '0);
      outGrid1   <= (32'(tileCol) >= GRID_COLS) || (32'(tileRow) >= GRID_ROWS);
      sliderHit1 <= nearAxis(iVGA_X, sliderX, SLD_HW) && nearAxis(iVGA_Y, sliderY, SLD_HH);
      ballHit1   <= nearAxis(iVGA_X, ballX, BALL_L) && nearAxis(iVGA_Y, ballY, BALL_L);
      inA1       <= inSpan(iVGA_X, A_X0, A_X1) && inSpan(iVGA_Y, A_Y0, A_Y1);
      inB1       <= inSpan(iVGA_X, B_X0, B_X1) && inSpan(iVGA_Y, B_Y0, B_Y1);

      oRed     <= pixR;
      oGreen   <= pixG;
      oBlue    <= pixB;
      oHS      <= hs1;
      oVS      <= vs1;
      oBLANK_n <= blank1;
    end
  end

endmodule
